// File: rtl/sb_pkg.sv
// Shared types and helpers for the register hazard scoreboard.
//   reg_idx_t : register index for the default 32-entry register file
//   X0        : index of the hard-wired zero register
//   cnt_w()   : width needed to hold a count 0..max inclusive
package sb_pkg;

   localparam int unsigned NREG_DEF = 32;
   localparam int unsigned RW_DEF   = $clog2(NREG_DEF);
   localparam int unsigned X0       = 0;

   typedef logic [RW_DEF-1:0] reg_idx_t;

   // Width of a counter that must represent 0..max_val inclusive.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage / completion-channel bundle for hazard_scoreboard.
//   master : decode + completion side (drives issue, sources, cpl_*, clr)
//   slave  : scoreboard side (drives stall_d, pending, outstanding, err_spurious)
interface hazard_scoreboard_if
   import sb_pkg::*;
#(
   parameter int unsigned NREG    = 32,
   parameter int unsigned NCH     = 2,
   parameter int unsigned MAX_OUT = 4
) ();
   localparam int unsigned RW = $clog2(NREG);
   localparam int unsigned OW = cnt_w(MAX_OUT);

   logic              issue_d;
   logic              flush_d;
   logic [RW-1:0]     rs1_d;
   logic [RW-1:0]     rs2_d;
   logic              use_rs1_d;
   logic              use_rs2_d;
   logic [RW-1:0]     rd_d;
   logic              wr_d;
   logic              long_d;
   logic [NCH-1:0]    cpl_valid;
   logic [NCH*RW-1:0] cpl_rd;
   logic              clr;
   logic              stall_d;
   logic [NREG-1:0]   pending;
   logic [OW-1:0]     outstanding;
   logic              err_spurious;

   modport master (
      output issue_d, flush_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d,
             rd_d, wr_d, long_d, cpl_valid, cpl_rd, clr,
      input  stall_d, pending, outstanding, err_spurious
   );

   modport slave (
      input  issue_d, flush_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d,
             rd_d, wr_d, long_d, cpl_valid, cpl_rd, clr,
      output stall_d, pending, outstanding, err_spurious
   );
endinterface

// File: rtl/sb_cpl_decode.sv
// Completion-channel decoder: folds NCH (valid, rd) channels into a one-hot
// clear mask, flags two channels naming one register, and counts how many
// of the cleared registers are actually pending.
//   cpl_valid_i  : per-channel strobe
//   cpl_rd_i     : per-channel register, channel k at [k*RW +: RW]
//   pending_i    : current pending mask
//   clr_mask_c_o : OR of decoded valid channels
//   dup_c_o      : two or more valid channels share a register
//   clr_cnt_c_o  : popcount(pending_i & clr_mask_c_o)
module sb_cpl_decode
   import sb_pkg::*;
#(
   parameter int unsigned NREG = 32,
   parameter int unsigned NCH  = 2
) (
   input  logic [NCH-1:0]               cpl_valid_i,
   input  logic [NCH*$clog2(NREG)-1:0]  cpl_rd_i,
   input  logic [NREG-1:0]              pending_i,
   output logic [NREG-1:0]              clr_mask_c_o,
   output logic                         dup_c_o,
   output logic [cnt_w(NCH)-1:0]        clr_cnt_c_o
);
   localparam int unsigned RW = $clog2(NREG);
   localparam int unsigned CW = cnt_w(NCH);

   logic [NREG-1:0] live_clr;

   // Decode channels; a channel hitting an already-set bit is a duplicate.
   always_comb begin
      clr_mask_c_o = '0;
      dup_c_o      = 1'b0;
      for (int k = 0; k < int'(NCH); k++) begin
         if (cpl_valid_i[k]) begin
            if (clr_mask_c_o[cpl_rd_i[k*RW +: RW]]) dup_c_o = 1'b1;
            clr_mask_c_o[cpl_rd_i[k*RW +: RW]] = 1'b1;
         end
      end
   end

   // Only registers that were really pending retire an operation.
   always_comb begin
      live_clr    = pending_i & clr_mask_c_o;
      clr_cnt_c_o = '0;
      for (int r = 0; r < int'(NREG); r++) begin
         clr_cnt_c_o = clr_cnt_c_o + CW'(live_clr[r]);
      end
   end
endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard for long-latency operations. Tracks destination
// registers owed by outstanding operations and stalls decode on RAW, WAW
// or capacity hazards until a completion channel retires the register.
//   clk, n_rst : clock, asynchronous active-low reset
//   sb         : decode/completion bundle (slave side)
//                stall_d is combinational; pending, outstanding and
//                err_spurious are registered.
module hazard_scoreboard
   import sb_pkg::*;
#(
   parameter int unsigned NREG    = 32,
   parameter int unsigned NCH     = 2,
   parameter int unsigned MAX_OUT = 4,
   parameter int unsigned BYPASS  = 1
) (
   input logic               clk,
   input logic               n_rst,
   hazard_scoreboard_if.slave sb
);
   localparam int unsigned RW  = $clog2(NREG);
   localparam int unsigned OW  = cnt_w(MAX_OUT);
   localparam int unsigned CW  = cnt_w(NCH);
   localparam bit          BYP = (BYPASS != 0);

   logic [NREG-1:0] pend_q, pend_d;
   logic [OW-1:0]   out_q, out_d;
   logic            err_q, err_d;

   logic [NREG-1:0] clr_mask;
   logic            dup;
   logic [CW-1:0]   clr_cnt;

   logic [NREG-1:0] eff_pend;
   logic            raw, waw, cap, stall, accept, real_clr;

   sb_cpl_decode #(
      .NREG (NREG),
      .NCH  (NCH)
   ) u_cpl_decode (
      .cpl_valid_i  (sb.cpl_valid),
      .cpl_rd_i     (sb.cpl_rd),
      .pending_i    (pend_q),
      .clr_mask_c_o (clr_mask),
      .dup_c_o      (dup),
      .clr_cnt_c_o  (clr_cnt)
   );

   // Hazard detection and next-state computation.
   always_comb begin
      eff_pend = pend_q & ~({NREG{BYP}} & clr_mask);
      // Capacity is relieved only by a genuine retirement, so the count
      // can never exceed MAX_OUT.
      real_clr = |(pend_q & clr_mask);
      raw      = (sb.use_rs1_d & eff_pend[sb.rs1_d]) |
                 (sb.use_rs2_d & eff_pend[sb.rs2_d]);
      waw      = sb.wr_d & eff_pend[sb.rd_d];
      cap      = sb.long_d & sb.wr_d & (out_q == OW'(MAX_OUT)) & ~(BYP & real_clr);
      stall    = sb.issue_d & ~sb.flush_d & (raw | waw | cap);
      accept   = sb.issue_d & ~sb.flush_d & ~stall & sb.long_d & sb.wr_d &
                 (sb.rd_d != RW'(X0));

      pend_d = pend_q & ~clr_mask;
      if (accept) pend_d[sb.rd_d] = 1'b1;
      pend_d[0] = 1'b0;
      out_d  = out_q + OW'(accept) - OW'(clr_cnt);
      err_d  = err_q | dup | (|(clr_mask & ~pend_q));

      if (sb.clr) begin
         pend_d = '0;
         out_d  = '0;
         err_d  = 1'b0;
      end
   end

   // Scoreboard state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pend_q <= '0;
         out_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         out_q  <= out_d;
         err_q  <= err_d;
      end
   end

   assign sb.stall_d      = stall;
   assign sb.pending      = pend_q;
   assign sb.outstanding  = out_q;
   assign sb.err_spurious = err_q;
endmodule
